// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer: two-entry execute-to-writeback FIFO with a combinational forwarding lookup
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ex_valid/ex_ready                execute-side handshake (ready never depends on wb_ready)
//   ex_sel_shift, result_shifter,
//   result_alu, ex_rd, ex_we         completed uop: result select, both results, destination, write enable
//   flush                            synchronous discard of all buffered entries
//   wb_valid/wb_ready                writeback-side handshake
//   wb_rd, wb_data, wb_we            head entry (all zero when wb_valid = 0)
//   lookup_rs1/2, fwd_hit1/2,
//   fwd_data1/2                      forwarding lookup over buffered writes
//   occupancy                        number of valid entries
module ex_wb_buffer #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic                      ex_sel_shift,
   input  logic [DATA_WIDTH-1:0]     result_shifter,
   input  logic [DATA_WIDTH-1:0]     result_alu,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      ex_we,
   input  logic                      flush,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic                      wb_we,
   input  logic [REG_ADDR_WIDTH-1:0] lookup_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] lookup_rs2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [DATA_WIDTH-1:0]     fwd_data1,
   output logic [DATA_WIDTH-1:0]     fwd_data2,
   output logic [1:0]                occupancy
);
   logic [REG_ADDR_WIDTH-1:0] rd_q   [2];
   logic [DATA_WIDTH-1:0]     data_q [2];
   logic                      we_q   [2];
   logic                      head, tail;
   logic [1:0]                count;
   logic                      push, pop;
   logic                      young, old;
   logic                      hy1, ho1, hy2, ho2;

   assign ex_ready  = (count != 2'd2) & ~flush;
   assign wb_valid  = count != 2'd0;
   assign push      = ex_valid & ex_ready;
   assign pop       = wb_valid & wb_ready;
   assign occupancy = count;
   assign wb_rd     = wb_valid ? rd_q[head]   : '0;
   assign wb_data   = wb_valid ? data_q[head] : '0;
   assign wb_we     = wb_valid & we_q[head];

   // Youngest entry sits just behind tail; the other slot is valid only when full.
   // Stored we is already cleared for rd 0, so index 0 can never match.
   assign young = ~tail;
   assign old   = tail;
   assign hy1   = wb_valid & we_q[young] & (rd_q[young] == lookup_rs1);
   assign ho1   = (count == 2'd2) & we_q[old] & (rd_q[old] == lookup_rs1);
   assign hy2   = wb_valid & we_q[young] & (rd_q[young] == lookup_rs2);
   assign ho2   = (count == 2'd2) & we_q[old] & (rd_q[old] == lookup_rs2);

   assign fwd_hit1  = hy1 | ho1;
   assign fwd_hit2  = hy2 | ho2;
   assign fwd_data1 = hy1 ? data_q[young] : ho1 ? data_q[old] : '0;
   assign fwd_data2 = hy2 ? data_q[young] : ho2 ? data_q[old] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q   <= '{default: '0};
         data_q <= '{default: '0};
         we_q   <= '{default: 1'b0};
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            rd_q[tail]   <= ex_rd;
            data_q[tail] <= ex_sel_shift ? result_shifter : result_alu;
            we_q[tail]   <= ex_we & (ex_rd != '0);
         end
         if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
         end else begin
            tail  <= tail ^ push;
            head  <= head ^ pop;
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end
endmodule
